// File: rtl/pattern_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pattern_sequencer_if
// Description : Pattern-memory write bus between the pattern-load path and
//               pattern_sequencer.
//               wr_en   - write strobe
//               wr_addr - {phase, step}; MSB 1 selects the P table
//               wr_data - {tweak_enable, drive}; drive in the LSBs
//               master  - pattern-load side (drives the bus)
//               slave   - sequencer side (receives the bus)
// Revision    : 1.0 - initial release
// ============================================================================
interface pattern_sequencer_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 3
) ();
  logic                 wr_en;
  logic [STEP_W:0]      wr_addr;
  logic [2*WIDTH-1:0]   wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pattern_sequencer
// Description : Per-phase pattern sequencer. Each phase has its own table of
//               NO_STEPS entries that are stepped on a programmable dwell.
//               Every pwm change forces a programmable dead-time, during
//               which the drivers are held at their safe values.
// Ports       : clk          - rising-edge clock
//               reset        - asynchronous, active-low reset
//               pwm          - phase select (1 = P phase, 0 = N phase)
//               dead_cycles  - dead-time length in cycles (0 acts as 1)
//               step_dwell   - each step lasts step_dwell+1 cycles
//               step_last    - index of the final step
//               wrap_mode    - 1 = wrap to step 0, 0 = hold step_last
//               wr_bus       - pattern memory write bus (slave modport)
//               p_drive      - P-driver gates, active low
//               n_drive      - N-driver gates, active high
//               tweak_enable - tweak enables
//               in_dead      - high while in the DEAD state
//               step_out     - current step index
//               interlock_err- sticky guard-override flag (macro builds only)
// Options     : PATSEQ_INTERLOCK_EN - adds a final P/N overlap guard and the
//               interlock_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_sequencer #(
  parameter int WIDTH    = 8,
  parameter int NO_STEPS = 8,
  parameter int STEP_W   = 3,
  parameter int DT_W     = 4,
  parameter int DWELL_W  = 8
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                pwm,
  input  wire logic [DT_W-1:0]     dead_cycles,
  input  wire logic [DWELL_W-1:0]  step_dwell,
  input  wire logic [STEP_W-1:0]   step_last,
  input  wire logic                wrap_mode,
  pattern_sequencer_if.slave       wr_bus,
  output logic [WIDTH-1:0]         p_drive,
  output logic [WIDTH-1:0]         n_drive,
  output logic [WIDTH-1:0]         tweak_enable,
  output logic                     in_dead,
  output logic [STEP_W-1:0]        step_out
`ifdef PATSEQ_INTERLOCK_EN
  ,
  output logic                     interlock_err
`endif
);

  localparam logic [DT_W-1:0]    C_DT_ONE    = 1;
  localparam logic [DWELL_W-1:0] C_DWELL_ONE = 1;
  localparam logic [STEP_W-1:0]  C_STEP_ONE  = 1;

  typedef enum logic [0:0] {
    S_DEAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_pwm_q;
  logic [DT_W-1:0]      r_dead_cnt;
  logic [DT_W-1:0]      w_dead_cnt_nxt;
  logic [DWELL_W-1:0]   r_dwell_cnt;
  logic [DWELL_W-1:0]   w_dwell_cnt_nxt;
  logic [STEP_W-1:0]    r_step;
  logic [STEP_W-1:0]    w_step_nxt;

  logic                 w_edge;
  logic [DT_W-1:0]      w_dead_last;

  logic [2*WIDTH-1:0]   r_mem [2*NO_STEPS];
  logic [2*WIDTH-1:0]   w_entry;
  logic [WIDTH-1:0]     w_p_raw;
  logic [WIDTH-1:0]     w_n_raw;
  logic [WIDTH-1:0]     w_tw_raw;
  logic [WIDTH-1:0]     w_p_out;

  assign w_edge      = pwm ^ r_pwm_q;
  // A zero dead_cycles still yields one safe cycle.
  assign w_dead_last = (dead_cycles == '0) ? '0 : (dead_cycles - C_DT_ONE);

  // --------------------------------------------------------------------------
  // Pattern memory: plain flops, no reset, no stall on sequencing.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_bus.wr_en) begin
      r_mem[wr_bus.wr_addr] <= wr_bus.wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm_q     <= 1'b0;
      r_state     <= S_DEAD;
      r_dead_cnt  <= '0;
      r_dwell_cnt <= '0;
      r_step      <= '0;
    end else begin
      r_pwm_q     <= pwm;
      r_state     <= w_state_nxt;
      r_dead_cnt  <= w_dead_cnt_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
      r_step      <= w_step_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_dead_cnt_nxt  = r_dead_cnt;
    w_dwell_cnt_nxt = r_dwell_cnt;
    w_step_nxt      = r_step;

    if (w_edge) begin
      // Any phase change (including one during dead-time) restarts dead-time.
      w_state_nxt    = S_DEAD;
      w_dead_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_DEAD: begin
          // >= rather than == so a runtime shrink of dead_cycles below the
          // running count exits promptly instead of wrapping the counter.
          if (r_dead_cnt >= w_dead_last) begin
            w_state_nxt     = S_RUN;
            w_step_nxt      = '0;
            w_dwell_cnt_nxt = '0;
          end else begin
            w_dead_cnt_nxt = r_dead_cnt + C_DT_ONE;
          end
        end
        S_RUN: begin
          if (r_dwell_cnt == step_dwell) begin
            w_dwell_cnt_nxt = '0;
            // step >= step_last covers step_last being lowered under us.
            if (r_step < step_last) begin
              w_step_nxt = r_step + C_STEP_ONE;
            end else if (wrap_mode) begin
              w_step_nxt = '0;
            end
          end else begin
            w_dwell_cnt_nxt = r_dwell_cnt + C_DWELL_ONE;
          end
        end
        default: begin
          w_state_nxt    = S_DEAD;
          w_dead_cnt_nxt = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output selection from current state, registered phase and step.
  // --------------------------------------------------------------------------
  assign w_entry = r_mem[{r_pwm_q, r_step}];

  always_comb begin
    w_p_raw  = '1;
    w_n_raw  = '0;
    w_tw_raw = '0;
    if (r_state == S_RUN) begin
      w_tw_raw = w_entry[2*WIDTH-1:WIDTH];
      if (r_pwm_q) begin
        w_p_raw = w_entry[WIDTH-1:0];
      end else begin
        w_n_raw = w_entry[WIDTH-1:0];
      end
    end
  end

`ifdef PATSEQ_INTERLOCK_EN
  logic w_override;
  // Turn a P gate off (active low) wherever its N partner would be on.
  assign w_p_out    = w_p_raw | w_n_raw;
  assign w_override = |(w_n_raw & ~w_p_raw);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      interlock_err <= 1'b0;
    end else if (w_override) begin
      interlock_err <= 1'b1;
    end
  end
`else
  assign w_p_out = w_p_raw;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_drive      <= '1;
      n_drive      <= '0;
      tweak_enable <= '0;
      in_dead      <= 1'b1;
      step_out     <= '0;
    end else begin
      p_drive      <= w_p_out;
      n_drive      <= w_n_raw;
      tweak_enable <= w_tw_raw;
      in_dead      <= (r_state == S_DEAD);
      step_out     <= r_step;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_sequencer
// Description : Directed self-checking bench for pattern_sequencer.
//               Tables: N[i] = {8'h40+i, 8'h10+i}, P[i] = {8'hC1+i, 8'h01+i}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwm = 1'b0;
  logic [3:0] dead_cycles = 4'd3;
  logic [7:0] step_dwell = 8'd0;
  logic [2:0] step_last = 3'd7;
  logic       wrap_mode = 1'b1;
  logic [7:0] p_drive;
  logic [7:0] n_drive;
  logic [7:0] tweak_enable;
  logic       in_dead;
  logic [2:0] step_out;
`ifdef PATSEQ_INTERLOCK_EN
  logic       interlock_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  pattern_sequencer_if #(.WIDTH(8), .STEP_W(3)) bus ();

  pattern_sequencer #(
    .WIDTH(8), .NO_STEPS(8), .STEP_W(3), .DT_W(4), .DWELL_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm          (pwm),
    .dead_cycles  (dead_cycles),
    .step_dwell   (step_dwell),
    .step_last    (step_last),
    .wrap_mode    (wrap_mode),
    .wr_bus       (bus.slave),
    .p_drive      (p_drive),
    .n_drive      (n_drive),
    .tweak_enable (tweak_enable),
    .in_dead      (in_dead),
    .step_out     (step_out)
`ifdef PATSEQ_INTERLOCK_EN
    ,
    .interlock_err(interlock_err)
`endif
  );

  always #5 clk = ~clk;

  logic [27:0] obs;
  assign obs = {p_drive, n_drive, tweak_enable, in_dead, step_out};

  localparam logic [24:0] SAFE_HI = {8'hFF, 8'h00, 8'h00, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tables();
    for (int i = 0; i < 8; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = {1'b0, 3'(i)};
      bus.wr_data = {8'h40 + 8'(i), 8'h10 + 8'(i)};
      tick();
      bus.wr_addr = {1'b1, 3'(i)};
      bus.wr_data = {8'hC1 + 8'(i), 8'h01 + 8'(i)};
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] exp;
    int idx;
    #2 reset = 1'b0;
    load_tables();
    exp = {SAFE_HI, 3'd0};
    vectors++;
    if (obs !== exp) begin
      $display("FAIL reset_state: got %h want %h", obs, exp);
      miscompares++;
    end
`ifdef PATSEQ_INTERLOCK_EN
    vectors++;
    if (interlock_err !== 1'b0) begin
      $display("FAIL reset_interlock_err: got %b want 0", interlock_err);
      miscompares++;
    end
`endif
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (obs !== exp) begin
        $display("FAIL reset_dead_%0d: got %h want %h", k, obs, exp);
        miscompares++;
      end
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      idx = k % 8;
      exp = {8'hFF, 8'h10 + 8'(idx), 8'h40 + 8'(idx), 1'b0, 3'(idx)};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL n_seq_%0d: got %h want %h", k, obs, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_p_wrap();
    logic [27:0] exp;
    int idx;
    dead_cycles = 4'd2; step_dwell = 8'd1; step_last = 3'd3; wrap_mode = 1'b1;
    pwm = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (obs[27:3] !== SAFE_HI) begin
        $display("FAIL p_wrap_dead_%0d: got %h want %h", k, obs[27:3], SAFE_HI);
        miscompares++;
      end
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      idx = (k / 2) % 4;
      exp = {8'h01 + 8'(idx), 8'h00, 8'hC1 + 8'(idx), 1'b0, 3'(idx)};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL p_wrap_seq_%0d: got %h want %h", k, obs, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_p_hold();
    logic [27:0] exp;
    int idx;
    wrap_mode = 1'b0;
    pwm = 1'b0;
    repeat (6) tick();
    pwm = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (obs[27:3] !== SAFE_HI) begin
        $display("FAIL p_hold_dead_%0d: got %h want %h", k, obs[27:3], SAFE_HI);
        miscompares++;
      end
    end
    for (int k = 0; k < 14; k++) begin
      tick();
      idx = (k / 2 > 3) ? 3 : k / 2;
      exp = {8'h01 + 8'(idx), 8'h00, 8'hC1 + 8'(idx), 1'b0, 3'(idx)};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL p_hold_seq_%0d: got %h want %h", k, obs, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_dead_restart();
    logic [27:0] exp;
    dead_cycles = 4'd4;
    pwm = 1'b0;
    tick();
    exp = {8'h04, 8'h00, 8'hC4, 1'b0, 3'd3};
    vectors++;
    if (obs !== exp) begin
      $display("FAIL restart_first_edge: got %h want %h", obs, exp);
      miscompares++;
    end
    pwm = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (obs[27:3] !== SAFE_HI) begin
        $display("FAIL restart_dead_%0d: got %h want %h", k, obs[27:3], SAFE_HI);
        miscompares++;
      end
    end
    tick();
    exp = {8'h01, 8'h00, 8'hC1, 1'b0, 3'd0};
    vectors++;
    if (obs !== exp) begin
      $display("FAIL restart_run: got %h want %h", obs, exp);
      miscompares++;
    end
  endtask

  task automatic test_write_through();
    logic [27:0] exp;
    step_dwell = 8'd255; dead_cycles = 4'd1;
    pwm = 1'b0;
    tick();
    tick();
    vectors++;
    if (obs[27:3] !== SAFE_HI) begin
      $display("FAIL wr_dead: got %h want %h", obs[27:3], SAFE_HI);
      miscompares++;
    end
    tick();
    exp = {8'hFF, 8'h10, 8'h40, 1'b0, 3'd0};
    vectors++;
    if (obs !== exp) begin
      $display("FAIL wr_before: got %h want %h", obs, exp);
      miscompares++;
    end
    bus.wr_en = 1'b1; bus.wr_addr = 4'b0000; bus.wr_data = 16'hA55A;
    tick();
    bus.wr_en = 1'b0;
    vectors++;
    if (obs !== exp) begin
      $display("FAIL wr_one_cycle: got %h want %h", obs, exp);
      miscompares++;
    end
    tick();
    exp = {8'hFF, 8'h5A, 8'hA5, 1'b0, 3'd0};
    vectors++;
    if (obs !== exp) begin
      $display("FAIL wr_two_cycles: got %h want %h", obs, exp);
      miscompares++;
    end
  endtask

  task automatic test_async_reset();
    logic [27:0] exp;
    step_dwell = 8'd1; step_last = 3'd3; wrap_mode = 1'b1; dead_cycles = 4'd2;
    pwm = 1'b1;
    tick();
    repeat (2) tick();
    repeat (3) tick();
    exp = {8'h02, 8'h00, 8'hC2, 1'b0, 3'd1};
    vectors++;
    if (obs !== exp) begin
      $display("FAIL ares_running: got %h want %h", obs, exp);
      miscompares++;
    end
    #2 reset = 1'b0;
    #1;
    exp = {SAFE_HI, 3'd0};
    vectors++;
    if (obs !== exp) begin
      $display("FAIL ares_immediate: got %h want %h", obs, exp);
      miscompares++;
    end
    pwm = 1'b0; dead_cycles = 4'd0;
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (obs !== exp) begin
      $display("FAIL ares_dead0: got %h want %h", obs, exp);
      miscompares++;
    end
    tick();
    exp = {8'hFF, 8'h5A, 8'hA5, 1'b0, 3'd0};
    vectors++;
    if (obs !== exp) begin
      $display("FAIL ares_run0a: got %h want %h", obs, exp);
      miscompares++;
    end
    tick();
    vectors++;
    if (obs !== exp) begin
      $display("FAIL ares_run0b: got %h want %h", obs, exp);
      miscompares++;
    end
    tick();
    exp = {8'hFF, 8'h11, 8'h41, 1'b0, 3'd1};
    vectors++;
    if (obs !== exp) begin
      $display("FAIL ares_run1: got %h want %h", obs, exp);
      miscompares++;
    end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    test_reset();
    test_p_wrap();
    test_p_hold();
    test_dead_restart();
    test_write_through();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
